// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: accepts instructions from fetch,
// drives the synchronous register file's read addresses, and issues a
// registered decode bundle plus pass-through operands to EX.
// Ports: clk, rst (async, active-high); fetch side instrIn/pcIn/instrValid/
// instrReady, flush; regfile readReg1/2 out, readData1/2 in; EX side
// exValid/exReady, opA/opB, imm, pcOut, rd, aluOp, funct3 and control flags.
// Optional load-use bubble: define DECODE_LOADUSE_STALL_EN.
module decode_stage #(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] instrIn,
    input  logic [DATAWIDTH-1:0] pcIn,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic                 flush,
    output logic [REGADDR-1:0]   readReg1,
    output logic [REGADDR-1:0]   readReg2,
    input  logic [DATAWIDTH-1:0] readData1,
    input  logic [DATAWIDTH-1:0] readData2,
    output logic                 exValid,
    input  logic                 exReady,
    output logic [DATAWIDTH-1:0] opA,
    output logic [DATAWIDTH-1:0] opB,
    output logic [DATAWIDTH-1:0] imm,
    output logic [DATAWIDTH-1:0] pcOut,
    output logic [REGADDR-1:0]   rd,
    output logic [3:0]           aluOp,
    output logic [2:0]           funct3,
    output logic                 regWrite,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 isBranch,
    output logic                 isJal,
    output logic                 isJalr,
    output logic                 useImm,
    output logic                 illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [DATAWIDTH-1:0] pc;
        logic [DATAWIDTH-1:0] imm;
        logic [REGADDR-1:0]   rs1;
        logic [REGADDR-1:0]   rs2;
        logic [REGADDR-1:0]   rd;
        logic [3:0]           alu_op;
        logic [2:0]           funct3;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 is_branch;
        logic                 is_jal;
        logic                 is_jalr;
        logic                 use_imm;
        logic                 illegal;
    } dec_t;

    dec_t bundle_q, bundle_d, dec_in;
    logic ex_valid_q, ex_valid_d;
    logic lu_stall;
    logic accept;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [31:0] imm32;

    assign opcode = instrIn[6:0];
    assign f3     = instrIn[14:12];

    always_comb begin
        dec_in        = '0;
        imm32         = '0;
        dec_in.pc     = pcIn;
        dec_in.rs1    = REGADDR'(instrIn[19:15]);
        dec_in.rs2    = REGADDR'(instrIn[24:20]);
        dec_in.funct3 = f3;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {instrIn[31:12], 12'b0};
                dec_in.reg_write = 1'b1;
                dec_in.use_imm   = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{11{instrIn[31]}}, instrIn[31],
                         instrIn[19:12], instrIn[20],
                         instrIn[30:21], 1'b0};
                dec_in.reg_write = 1'b1;
                dec_in.is_jal    = 1'b1;
                dec_in.use_imm   = 1'b1;
            end
            OPC_JALR: begin
                imm32 = {{20{instrIn[31]}}, instrIn[31:20]};
                dec_in.reg_write = 1'b1;
                dec_in.is_jalr   = 1'b1;
                dec_in.use_imm   = 1'b1;
            end
            OPC_BRANCH: begin
                imm32 = {{19{instrIn[31]}}, instrIn[31],
                         instrIn[7], instrIn[30:25],
                         instrIn[11:8], 1'b0};
                dec_in.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                imm32 = {{20{instrIn[31]}}, instrIn[31:20]};
                dec_in.reg_write = 1'b1;
                dec_in.mem_read  = 1'b1;
                dec_in.use_imm   = 1'b1;
            end
            OPC_STORE: begin
                imm32 = {{20{instrIn[31]}}, instrIn[31:25],
                         instrIn[11:7]};
                dec_in.mem_write = 1'b1;
                dec_in.use_imm   = 1'b1;
            end
            OPC_OPIMM: begin
                imm32 = {{20{instrIn[31]}}, instrIn[31:20]};
                dec_in.reg_write = 1'b1;
                dec_in.use_imm   = 1'b1;
                // only SRAI uses funct7[5]; other immediates own bit 30
                dec_in.alu_op = {instrIn[30] & (f3 == 3'b101), f3};
            end
            OPC_OP: begin
                dec_in.reg_write = 1'b1;
                dec_in.alu_op    = {instrIn[30], f3};
            end
            default: begin
                dec_in.illegal = 1'b1;
            end
        endcase
        dec_in.imm = DATAWIDTH'($signed(imm32));
        dec_in.rd  = dec_in.reg_write ?
                     REGADDR'(instrIn[11:7]) : '0;
    end

`ifdef DECODE_LOADUSE_STALL_EN
    logic use_rs1, use_rs2;
    logic hit1, hit2;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (opcode)
            OPC_BRANCH, OPC_STORE, OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
            end
        endcase
    end

    assign hit1 = use_rs1 && (dec_in.rs1 == bundle_q.rd);
    assign hit2 = use_rs2 && (dec_in.rs2 == bundle_q.rd);
    // loaded value is not in the regfile yet: insert one bubble
    assign lu_stall = ex_valid_q && bundle_q.mem_read &&
                      (bundle_q.rd != '0) && exReady &&
                      (hit1 || hit2);
`else
    assign lu_stall = 1'b0;
`endif

    assign instrReady = !flush && (!ex_valid_q || exReady) &&
                        !lu_stall;
    assign accept = instrValid && instrReady;

    // while not ready, keep re-reading held sources so WB writes land
    assign readReg1 = instrReady ? dec_in.rs1 : bundle_q.rs1;
    assign readReg2 = instrReady ? dec_in.rs2 : bundle_q.rs2;

    always_comb begin
        bundle_d   = bundle_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            bundle_d   = '0;
            ex_valid_d = 1'b0;
        end else if (accept) begin
            bundle_d   = dec_in;
            ex_valid_d = 1'b1;
        end else if (ex_valid_q && exReady) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q   <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            bundle_q   <= bundle_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // regfile allows writes to x0, so zero it here
    assign opA = (bundle_q.rs1 == '0) ? '0 : readData1;
    assign opB = (bundle_q.rs2 == '0) ? '0 : readData2;

    assign exValid  = ex_valid_q;
    assign imm      = bundle_q.imm;
    assign pcOut    = bundle_q.pc;
    assign rd       = bundle_q.rd;
    assign aluOp    = bundle_q.alu_op;
    assign funct3   = bundle_q.funct3;
    assign regWrite = bundle_q.reg_write;
    assign memRead  = bundle_q.mem_read;
    assign memWrite = bundle_q.mem_write;
    assign isBranch = bundle_q.is_branch;
    assign isJal    = bundle_q.is_jal;
    assign isJalr   = bundle_q.is_jalr;
    assign useImm   = bundle_q.use_imm;
    assign illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then randomized traffic
// against a behavioural decode/handshake reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrIn, pcIn;
    logic        instrValid, instrReady, flush;
    logic [4:0]  readReg1, readReg2;
    logic [31:0] readData1, readData2;
    logic        exValid, exReady;
    logic [31:0] opA, opB, imm, pcOut;
    logic [4:0]  rd;
    logic [3:0]  aluOp;
    logic [2:0]  funct3;
    logic        regWrite, memRead, memWrite, isBranch;
    logic        isJal, isJalr, useImm, illegal;
    logic [7:0]  flags_o;

    logic [31:0] regs [32];
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .instrIn(instrIn), .pcIn(pcIn),
        .instrValid(instrValid), .instrReady(instrReady),
        .flush(flush),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .exValid(exValid), .exReady(exReady),
        .opA(opA), .opB(opB), .imm(imm), .pcOut(pcOut),
        .rd(rd), .aluOp(aluOp), .funct3(funct3),
        .regWrite(regWrite), .memRead(memRead),
        .memWrite(memWrite), .isBranch(isBranch),
        .isJal(isJal), .isJalr(isJalr),
        .useImm(useImm), .illegal(illegal)
    );

    assign flags_o = {regWrite, memRead, memWrite, isBranch,
                      isJal, isJalr, useImm, illegal};

    // synchronous-read register file (old data on read/write collision)
    always @(posedge clk) begin
        if (we) regs[wa] <= wd;
        readData1 <= regs[readReg1];
        readData2 <= regs[readReg2];
    end

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [7:0]  flags;
        logic        use1;
        logic        use2;
    } ref_t;

    function automatic int sx(input logic [31:0] i, input int w);
        return i[31] ? -w : 0;
    endfunction

    function automatic ref_t ref_dec(input logic [31:0] i);
        ref_t r;
        logic [2:0] f3;
        r  = '0;
        f3 = i[14:12];
        case (i[6:0])
            7'h37, 7'h17: begin
                r.imm   = i & 32'hFFFFF000;
                r.flags = 8'h82;
            end
            7'h6F: begin
                r.imm = 32'(sx(i, 1048576) + int'(i[19:12]) * 4096
                      + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
                r.flags = 8'h8A;
            end
            7'h67: begin
                r.imm   = 32'(sx(i, 2048) + int'(i[30:20]));
                r.flags = 8'h86;
                r.use1  = 1'b1;
            end
            7'h63: begin
                r.imm = 32'(sx(i, 4096) + int'(i[7]) * 2048
                      + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
                r.flags = 8'h10;
                r.use1  = 1'b1;
                r.use2  = 1'b1;
            end
            7'h03: begin
                r.imm   = 32'(sx(i, 2048) + int'(i[30:20]));
                r.flags = 8'hC2;
                r.use1  = 1'b1;
            end
            7'h23: begin
                r.imm = 32'(sx(i, 2048) + int'(i[30:25]) * 32
                      + int'(i[11:7]));
                r.flags = 8'h22;
                r.use1  = 1'b1;
                r.use2  = 1'b1;
            end
            7'h13: begin
                r.imm   = 32'(sx(i, 2048) + int'(i[30:20]));
                r.flags = 8'h82;
                r.alu   = {i[30] && (f3 == 3'd5), f3};
                r.use1  = 1'b1;
            end
            7'h33: begin
                r.flags = 8'h80;
                r.alu   = {i[30], f3};
                r.use1  = 1'b1;
                r.use2  = 1'b1;
            end
            default: r.flags = 8'h01;
        endcase
        r.rd = r.flags[7] ? i[11:7] : 5'd0;
        return r;
    endfunction

    function automatic logic [31:0] src(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                             7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};

    initial begin : main
        logic        m_valid;
        logic [31:0] m_instr, m_pc, ins;
        ref_t        dh, di;
        logic        lu, exp_rdy;

        rst = 1'b1; flush = 1'b0; instrValid = 1'b0;
        exReady = 1'b0; instrIn = 32'h13; pcIn = '0;
        we = 1'b0; wa = '0; wd = '0;

        // preload regfile; x0 holds garbage to prove zeroing
        for (int k = 0; k < 32; k++) begin
            we = 1'b1;
            wa = 5'(k);
            wd = (k == 0) ? 32'hDEADBEEF : (k == 1) ? 32'd7 :
                 (k == 2) ? 32'd9 : $urandom;
            tick();
        end
        we = 1'b0;

        chk("rst_exvalid", 32'(exValid), 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(instrReady), 32'd1);

        // addi x5,x0,-1
        instrValid = 1'b1; instrIn = 32'hFFF00293; pcIn = 32'h100;
        #1;
        chk("addi_rdy", 32'(instrReady), 32'd1);
        tick();
        instrValid = 1'b0;
        #1;
        chk("addi_valid", 32'(exValid), 32'd1);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(rd), 32'd5);
        chk("addi_flags", 32'(flags_o), 32'h82);
        chk("addi_opA", opA, 32'd0);
        chk("addi_alu", 32'(aluOp), 32'd0);
        chk("addi_pc", pcOut, 32'h100);
        chk("addi_hold_rdy", 32'(instrReady), 32'd0);

        // asynchronous reset mid-cycle while holding a bundle
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(exValid), 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        chk("arst_flags", 32'(flags_o), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("arst_ready", 32'(instrReady), 32'd1);
        tick();

        // add x3,x1,x2 stalled 3 cycles while WB writes x1=11
        instrValid = 1'b1; instrIn = 32'h002081B3; pcIn = 32'h200;
        tick();
        instrIn = 32'h00000013;
        #1;
        chk("add_valid", 32'(exValid), 32'd1);
        chk("add_opA0", opA, 32'd7);
        chk("add_opB0", opB, 32'd9);
        chk("add_rdy0", 32'(instrReady), 32'd0);
        chk("add_rr1", 32'(readReg1), 32'd1);
        we = 1'b1; wa = 5'd1; wd = 32'd11;
        tick();
        we = 1'b0;
        #1;
        chk("add_opA1", opA, 32'd7);
        tick();
        chk("add_opA2", opA, 32'd11);
        chk("add_rd2", 32'(rd), 32'd3);
        chk("add_rdy2", 32'(instrReady), 32'd0);
        exReady = 1'b1; instrValid = 1'b0;
        #1;
        chk("add_issue", 32'(exValid), 32'd1);
        chk("add_opA3", opA, 32'd11);
        tick();
        chk("add_drain", 32'(exValid), 32'd0);

        // lw x4,0(x1) ; add x6,x4,x4
        instrValid = 1'b1; instrIn = 32'h0000A203; pcIn = 32'h300;
        #1;
        chk("lw_rdy", 32'(instrReady), 32'd1);
        tick();
        instrIn = 32'h00420333; pcIn = 32'h304;
        #1;
        chk("lw_rd", 32'(rd), 32'd4);
        chk("lw_flags", 32'(flags_o), 32'hC2);
`ifdef DECODE_LOADUSE_STALL_EN
        chk("lu_stall_rdy", 32'(instrReady), 32'd0);
        tick();
        chk("lu_bubble", 32'(exValid), 32'd0);
        chk("lu_rdy_after", 32'(instrReady), 32'd1);
        tick();
`else
        chk("lu_rdy", 32'(instrReady), 32'd1);
        tick();
`endif
        instrValid = 1'b0;
        #1;
        chk("dep_valid", 32'(exValid), 32'd1);
        chk("dep_rd", 32'(rd), 32'd6);
        tick();
        chk("dep_drain", 32'(exValid), 32'd0);

        // flush with held instr and a new offer
        exReady = 1'b0;
        instrValid = 1'b1; instrIn = 32'h00000013; pcIn = 32'h400;
        tick();
        instrIn = 32'h002081B3; flush = 1'b1;
        #1;
        chk("fl_rdy", 32'(instrReady), 32'd0);
        chk("fl_held", 32'(exValid), 32'd1);
        tick();
        flush = 1'b0; instrValid = 1'b0;
        #1;
        chk("fl_valid", 32'(exValid), 32'd0);
        chk("fl_rd", 32'(rd), 32'd0);
        tick();
        chk("fl_nottaken", 32'(exValid), 32'd0);

        // illegal opcode then sw x2,-4(x1)
        exReady = 1'b1;
        instrValid = 1'b1; instrIn = 32'h0000007F; pcIn = 32'h500;
        tick();
        instrIn = 32'hFE20AE23; pcIn = 32'h504;
        #1;
        chk("ill_flags", 32'(flags_o), 32'h01);
        chk("ill_rd", 32'(rd), 32'd0);
        tick();
        instrValid = 1'b0;
        #1;
        chk("sw_flags", 32'(flags_o), 32'h22);
        chk("sw_imm", imm, 32'hFFFFFFFC);
        chk("sw_rd", 32'(rd), 32'd0);
        chk("sw_opA", opA, 32'd11);
        chk("sw_opB", opB, 32'd9);
        tick();

        // randomized traffic against the reference model
        m_valid = 1'b0;
        m_instr = 32'hFE20AE23;
        m_pc    = 32'h504;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            instrIn    = ins;
            pcIn       = $urandom & 32'hFFFFFFFC;
            instrValid = ($urandom_range(0, 3) != 0);
            exReady    = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            #1;
            dh = ref_dec(m_instr);
            di = ref_dec(ins);
`ifdef DECODE_LOADUSE_STALL_EN
            lu = m_valid && dh.flags[6] && (dh.rd != 0) && exReady &&
                 ((di.use1 && ins[19:15] == dh.rd) ||
                  (di.use2 && ins[24:20] == dh.rd));
`else
            lu = 1'b0;
`endif
            exp_rdy = !flush && (!m_valid || exReady) && !lu;
            chk("r_ready", 32'(instrReady), 32'(exp_rdy));
            chk("r_valid", 32'(exValid), 32'(m_valid));
            chk("r_rr1", 32'(readReg1),
                32'(exp_rdy ? ins[19:15] : m_instr[19:15]));
            chk("r_rr2", 32'(readReg2),
                32'(exp_rdy ? ins[24:20] : m_instr[24:20]));
            if (m_valid) begin
                chk("r_imm", imm, dh.imm);
                chk("r_rd", 32'(rd), 32'(dh.rd));
                chk("r_alu", 32'(aluOp), 32'(dh.alu));
                chk("r_f3", 32'(funct3), 32'(m_instr[14:12]));
                chk("r_flags", 32'(flags_o), 32'(dh.flags));
                chk("r_pc", pcOut, m_pc);
                chk("r_opA", opA, src(m_instr[19:15]));
                chk("r_opB", opB, src(m_instr[24:20]));
            end
            if (flush) begin
                m_valid = 1'b0;
                m_instr = 32'h13;
            end else if (instrValid && exp_rdy) begin
                m_valid = 1'b1;
                m_instr = ins;
                m_pc    = pcIn;
            end else if (m_valid && exReady) begin
                m_valid = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
